// File: rtl/dmi_mux_buffer.sv
// dmi_mux_buffer: round-robin mux of NUM_CH DMI masters onto one
// DMI slave, in-order response return via a queue of channel IDs.
// Ports: clk_i, rst_i (async, active high), clear_i (sync drain);
//   ch_req_i/ch_valid_i/ch_ready_o      per-channel requests
//   ch_resp_o/ch_resp_valid_o/ch_resp_ready_i  responses to channels
//   dmi_req_o/dmi_req_valid_o/dmi_req_ready_i  request to slave
//   dmi_resp_i/dmi_resp_valid_i/dmi_resp_ready_o  slave response
//   busy_o (draining or outstanding), err_o (sticky stray response)
// Option: DMI_MUX_RESP_REG_EN adds a one-entry response register.
module dmi_mux_buffer #(
  parameter int NUM_CH  = 2,
  parameter int REQ_W   = 41,
  parameter int RESP_W  = 34,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [NUM_CH*REQ_W-1:0] ch_req_i,
  input  logic [NUM_CH-1:0]       ch_valid_i,
  output logic [NUM_CH-1:0]       ch_ready_o,
  output logic [RESP_W-1:0]       ch_resp_o,
  output logic [NUM_CH-1:0]       ch_resp_valid_o,
  input  logic [NUM_CH-1:0]       ch_resp_ready_i,
  output logic [REQ_W-1:0]        dmi_req_o,
  output logic                    dmi_req_valid_o,
  input  logic                    dmi_req_ready_i,
  input  logic [RESP_W-1:0]       dmi_resp_i,
  input  logic                    dmi_resp_valid_i,
  output logic                    dmi_resp_ready_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int CW = $clog2(NUM_CH);
  localparam int PW = $clog2(MAX_OUT);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUT);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     rr_q;
  logic [CW-1:0]     gnt_id;
  logic              gnt_found;
  logic              grant;
  logic              kill;
  logic              drain_m;
  logic              q_empty;
  logic              pop;
  logic              bad_resp;
  logic [REQ_W-1:0]  req_q;
  logic              req_vld_q;
  logic [CW-1:0]     id_mem [MAX_OUT];
  logic [PW-1:0]     wr_q, rd_q;
  logic [OW-1:0]     cnt_q, cnt_d, kill_n;
  logic [CW-1:0]     head_id;

  function automatic logic [CW-1:0] rr_idx(
    input logic [CW-1:0] p,
    input int            i
  );
    int j;
    j = int'(p) + i;
    if (j >= NUM_CH) j = j - NUM_CH;
    return CW'(j);
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_found && ch_valid_i[rr_idx(rr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_id    = rr_idx(rr_q, i);
      end
    end
  end

  // A request still waiting in the stage at clear time is withdrawn
  // and its ID taken back off the queue tail.
  assign kill    = clear_i && req_vld_q && !dmi_req_ready_i;
  assign kill_n  = {{(OW-1){1'b0}}, kill};
  assign drain_m = (state_q == DRAIN) || clear_i;
  assign q_empty = (cnt_q == kill_n);
  assign head_id = id_mem[rd_q];

  assign grant = (state_q == RUN) && !clear_i
              && (cnt_q < MAX_CNT)
              && (!req_vld_q || dmi_req_ready_i)
              && gnt_found;

  assign ch_ready_o = grant ? (NUM_CH'(1) << gnt_id) : '0;
  assign dmi_req_o       = req_q;
  assign dmi_req_valid_o = req_vld_q;
  assign busy_o = (state_q == DRAIN) || (cnt_q != '0);

`ifdef DMI_MUX_RESP_REG_EN
  logic [RESP_W-1:0] resp_q;
  logic [CW-1:0]     resp_id_q;
  logic              resp_vld_q;
  logic              resp_take;
  logic              load;

  assign resp_take = resp_vld_q && ch_resp_ready_i[resp_id_q];
  assign ch_resp_o = resp_q;

  always_comb begin
    ch_resp_valid_o = '0;
    ch_resp_valid_o[resp_id_q] = resp_vld_q;
    dmi_resp_ready_o = 1'b1;
    pop      = 1'b0;
    load     = 1'b0;
    bad_resp = 1'b0;
    if (q_empty) begin
      bad_resp = !drain_m && dmi_resp_valid_i;
    end else if (drain_m) begin
      pop = dmi_resp_valid_i;
    end else begin
      dmi_resp_ready_o = !resp_vld_q || resp_take;
      pop  = dmi_resp_valid_i && dmi_resp_ready_o;
      load = pop;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_q     <= '0;
      resp_id_q  <= '0;
      resp_vld_q <= 1'b0;
    end else if (clear_i) begin
      resp_vld_q <= 1'b0;
    end else if (load) begin
      resp_q     <= dmi_resp_i;
      resp_id_q  <= head_id;
      resp_vld_q <= 1'b1;
    end else if (resp_take) begin
      resp_vld_q <= 1'b0;
    end
  end
`else
  assign ch_resp_o = dmi_resp_i;

  always_comb begin
    ch_resp_valid_o  = '0;
    dmi_resp_ready_o = 1'b1;
    pop      = 1'b0;
    bad_resp = 1'b0;
    if (q_empty) begin
      bad_resp = !drain_m && dmi_resp_valid_i;
    end else if (drain_m) begin
      pop = dmi_resp_valid_i;
    end else begin
      dmi_resp_ready_o = ch_resp_ready_i[head_id];
      ch_resp_valid_o[head_id] = dmi_resp_valid_i;
      pop = dmi_resp_valid_i && ch_resp_ready_i[head_id];
    end
  end
`endif

  assign cnt_d = cnt_q + OW'(grant) - OW'(pop) - kill_n;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (clear_i) state_d = DRAIN;
      DRAIN: if (cnt_d == '0 && !clear_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      rr_q      <= '0;
      req_q     <= '0;
      req_vld_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      err_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        rr_q      <= rr_idx(gnt_id, 1);
        req_q     <= ch_req_i[int'(gnt_id)*REQ_W +: REQ_W];
        req_vld_q <= 1'b1;
        wr_q      <= wr_q + PW'(1);
      end else if (kill || dmi_req_ready_i) begin
        req_vld_q <= 1'b0;
      end
      if (kill) wr_q <= wr_q - PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      if (clear_i) err_o <= 1'b0;
      else if (bad_resp) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) id_mem[wr_q] <= gnt_id;
  end

endmodule

// File: tb/tb_dmi_mux_buffer.sv
// Directed bench for dmi_mux_buffer (either response build).
// Arbitration, queue limit, drain, stray response, back-pressure.
module tb_dmi_mux_buffer;
  logic        clk = 1'b0;
  logic        rst_i, clear_i;
  logic [81:0] ch_req_i;
  logic [1:0]  ch_valid_i, ch_ready_o;
  logic [33:0] ch_resp_o;
  logic [1:0]  ch_resp_valid_o, ch_resp_ready_i;
  logic [40:0] dmi_req_o;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  logic [33:0] dmi_resp_i;
  logic        dmi_resp_valid_i, dmi_resp_ready_o;
  logic        busy_o, err_o;

  localparam logic [40:0] P0 = {7'h11, 32'hCAFE_0000, 2'b01};
  localparam logic [40:0] P1 = {7'h22, 32'hBEEF_0001, 2'b10};

  int vecs = 0;
  int errs = 0;
  int ng;

  dmi_mux_buffer dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .ch_req_i(ch_req_i), .ch_valid_i(ch_valid_i),
    .ch_ready_o(ch_ready_o), .ch_resp_o(ch_resp_o),
    .ch_resp_valid_o(ch_resp_valid_o),
    .ch_resp_ready_i(ch_resp_ready_i),
    .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o),
    .dmi_req_ready_i(dmi_req_ready_i), .dmi_resp_i(dmi_resp_i),
    .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input logic [1:0] exp_v,
                     input logic [33:0] d);
    dmi_resp_i = d;
    dmi_resp_valid_i = 1'b1;
    #1;
    chk("rsp_rdy", 64'(dmi_resp_ready_o), 64'(1));
`ifdef DMI_MUX_RESP_REG_EN
    chk("rsp_vld0", 64'(ch_resp_valid_o), 64'(0));
    step();
    dmi_resp_valid_i = 1'b0;
    #1;
    chk("rsp_vld", 64'(ch_resp_valid_o), 64'(exp_v));
    chk("rsp_dat", 64'(ch_resp_o), 64'(d));
    step();
`else
    chk("rsp_vld", 64'(ch_resp_valid_o), 64'(exp_v));
    chk("rsp_dat", 64'(ch_resp_o), 64'(d));
    step();
    dmi_resp_valid_i = 1'b0;
`endif
  endtask

  initial begin
    rst_i = 1'b1;
    clear_i = 1'b0;
    ch_req_i = {P1, P0};
    ch_valid_i = '0;
    ch_resp_ready_i = '0;
    dmi_req_ready_i = 1'b0;
    dmi_resp_i = '0;
    dmi_resp_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rqv", 64'(dmi_req_valid_o), 64'(0));
    chk("rst_rsv", 64'(ch_resp_valid_o), 64'(0));
    chk("rst_rdy", 64'(ch_ready_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_drr", 64'(dmi_resp_ready_o), 64'(1));
    rst_i = 1'b0;
    step();

    // round robin, full throughput
    ch_valid_i = 2'b11;
    dmi_req_ready_i = 1'b1;
    ch_resp_ready_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt", 64'(ch_ready_o),
          (i % 2 == 1) ? 64'(2) : 64'(1));
      if (i > 0) begin
        chk("rr_req", 64'(dmi_req_o),
            (i % 2 == 1) ? 64'(P0) : 64'(P1));
        chk("rr_rqv", 64'(dmi_req_valid_o), 64'(1));
      end
      step();
    end
    #1;
    chk("rr_full", 64'(ch_ready_o), 64'(0));
    chk("rr_busy", 64'(busy_o), 64'(1));
    chk("rr_last", 64'(dmi_req_o), 64'(P1));
    ch_valid_i = 2'b00;
    step();
    rsp(2'b01, 34'h0_1111_1110);
    rsp(2'b10, 34'h0_2222_2221);
    rsp(2'b01, 34'h0_3333_3332);
    rsp(2'b10, 34'h0_4444_4443);
    #1;
    chk("rr_idle", 64'(busy_o), 64'(0));

    // outstanding limit on ch1
    step();
    ch_valid_i = 2'b10;
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      ng += int'(ch_ready_o[1]);
      step();
    end
    chk("max_gnt", 64'(ng), 64'(4));
    #1;
    chk("max_rdy", 64'(ch_ready_o), 64'(0));
    chk("max_busy", 64'(busy_o), 64'(1));
    chk("max_rqv", 64'(dmi_req_valid_o), 64'(0));
    ch_valid_i = 2'b00;
    rsp(2'b10, 34'h3_0000_0005);

    // clear with 3 outstanding
    ch_valid_i = 2'b10;
    clear_i = 1'b1;
    #1;
    chk("clr_rdy", 64'(ch_ready_o), 64'(0));
    step();
    clear_i = 1'b0;
    #1;
    chk("drn_busy", 64'(busy_o), 64'(1));
    chk("drn_rdy", 64'(ch_ready_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = 34'(i + 7);
      #1;
      chk("drn_drr", 64'(dmi_resp_ready_o), 64'(1));
      chk("drn_rsv", 64'(ch_resp_valid_o), 64'(0));
      step();
    end
    dmi_resp_valid_i = 1'b0;
    #1;
    chk("drn_done", 64'(busy_o), 64'(0));
    chk("drn_run", 64'(ch_ready_o), 64'(2));
    ch_valid_i = 2'b00;
    step();

    // stray response with empty queue
    dmi_resp_i = 34'h2_AAAA_5555;
    dmi_resp_valid_i = 1'b1;
    #1;
    chk("stray_drr", 64'(dmi_resp_ready_o), 64'(1));
    chk("stray_rsv", 64'(ch_resp_valid_o), 64'(0));
    step();
    dmi_resp_valid_i = 1'b0;
    #1;
    chk("stray_err", 64'(err_o), 64'(1));
    step();
    step();
    chk("stray_hold", 64'(err_o), 64'(1));
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    #1;
    chk("stray_clr", 64'(err_o), 64'(0));
    step();
    chk("stray_busy", 64'(busy_o), 64'(0));

    // response back-pressure
    ch_valid_i = 2'b01;
    #1;
    chk("bp_gnt0", 64'(ch_ready_o), 64'(1));
    step();
    chk("bp_gnt1", 64'(ch_ready_o), 64'(1));
    step();
    ch_valid_i = 2'b00;
    step();
    ch_resp_ready_i = 2'b00;
    dmi_resp_i = 34'h1_2345_6789;
    dmi_resp_valid_i = 1'b1;
`ifdef DMI_MUX_RESP_REG_EN
    #1;
    chk("bp_load", 64'(dmi_resp_ready_o), 64'(1));
    step();
    dmi_resp_i = 34'h0_9876_5432;
`endif
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_drr", 64'(dmi_resp_ready_o), 64'(0));
      chk("bp_vld", 64'(ch_resp_valid_o), 64'(1));
      chk("bp_dat", 64'(ch_resp_o), 64'(34'h1_2345_6789));
      step();
    end
    ch_resp_ready_i = 2'b11;
    #1;
    chk("bp_rel", 64'(dmi_resp_ready_o), 64'(1));
    step();
`ifdef DMI_MUX_RESP_REG_EN
    dmi_resp_valid_i = 1'b0;
    #1;
    chk("bp2_vld", 64'(ch_resp_valid_o), 64'(1));
    chk("bp2_dat", 64'(ch_resp_o), 64'(34'h0_9876_5432));
    step();
`else
    rsp(2'b01, 34'h0_9876_5432);
`endif
    #1;
    chk("bp_idle", 64'(busy_o), 64'(0));
    chk("bp_err", 64'(err_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
